// File: rtl/tag_release_queue_pkg.sv
// ---------------------------------------------------------------------------
// release_pkg
// Shared sizing, types and helpers for the tag release queue.
//   FL_DEPTH     : free-list depth (power of 2)
//   TAG_WIDTH    : width of a physical-register tag
//   QUEUE_DEPTH  : depth of the internal release FIFO (power of 2, >= 4)
//   QADDR_WIDTH  : FIFO index width; pointers carry one extra wrap bit
//   NUM_PORTS    : release slots per cycle and free-list write ports
// ---------------------------------------------------------------------------
package release_pkg;

  localparam int FL_DEPTH    = 32;
  localparam int TAG_WIDTH   = $clog2(FL_DEPTH);
  localparam int QUEUE_DEPTH = 8;
  localparam int QADDR_WIDTH = $clog2(QUEUE_DEPTH);
  localparam int NUM_PORTS   = 3;

  typedef logic [TAG_WIDTH-1:0]   tag_t;
  typedef logic [QADDR_WIDTH:0]   qptr_t;
  typedef logic [TAG_WIDTH:0]     flcnt_t;
  typedef logic [QADDR_WIDTH-1:0] qidx_t;

  // Number of set bits in a 3-slot valid vector (0..3).
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/tag_release_queue_if.sv
// ---------------------------------------------------------------------------
// tag_release_queue_if
// Bundles the commit-side release slots, the free-list write ports and the
// queue status signals of the tag release queue.
//   rel_valid_k / rel_tag_k     : commit release slot k (k = 0..2)
//   rel_ready                   : queue can take 3 releases this cycle
//   fl_count                    : current free-list occupancy
//   fl_write_en_k / _tag_k      : compacted free-list write ports
//   queue_count / queue_empty   : FIFO occupancy
//   overflow_err                : sticky dropped-release flag
// Modports:
//   slave  : the queue itself
//   master : the surrounding commit stage / free list (or a testbench)
// ---------------------------------------------------------------------------
interface tag_release_queue_if;
  import release_pkg::*;

  logic   rel_valid_0;
  logic   rel_valid_1;
  logic   rel_valid_2;
  tag_t   rel_tag_0;
  tag_t   rel_tag_1;
  tag_t   rel_tag_2;
  logic   rel_ready;
  flcnt_t fl_count;
  logic   fl_write_en_0;
  logic   fl_write_en_1;
  logic   fl_write_en_2;
  tag_t   fl_write_tag_0;
  tag_t   fl_write_tag_1;
  tag_t   fl_write_tag_2;
  qptr_t  queue_count;
  logic   queue_empty;
  logic   overflow_err;

  modport slave (
    input  rel_valid_0, rel_valid_1, rel_valid_2,
    input  rel_tag_0, rel_tag_1, rel_tag_2,
    input  fl_count,
    output rel_ready,
    output fl_write_en_0, fl_write_en_1, fl_write_en_2,
    output fl_write_tag_0, fl_write_tag_1, fl_write_tag_2,
    output queue_count, queue_empty, overflow_err
  );

  modport master (
    output rel_valid_0, rel_valid_1, rel_valid_2,
    output rel_tag_0, rel_tag_1, rel_tag_2,
    output fl_count,
    input  rel_ready,
    input  fl_write_en_0, fl_write_en_1, fl_write_en_2,
    input  fl_write_tag_0, fl_write_tag_1, fl_write_tag_2,
    input  queue_count, queue_empty, overflow_err
  );

endinterface

// File: rtl/tag_release_queue_compactor.sv
// ---------------------------------------------------------------------------
// slot_compactor_3
// Packs up to three valid/tag pairs into a dense list, preserving slot order,
// and reports how many entries are valid.
//   valid_i : per-slot valid bits, slot 0 in bit 0
//   tag_i   : per-slot tags
//   dense_o : valid tags packed from index 0 upward; unused entries are '0
//   count_o : number of valid slots (0..3)
// ---------------------------------------------------------------------------
module slot_compactor_3
  import release_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid_i,
  input  tag_t                 tag_i   [NUM_PORTS],
  output tag_t                 dense_o [NUM_PORTS],
  output logic [1:0]           count_o
);

  logic [1:0] cursor;

  // Walk the slots in order; each valid tag lands at the next free dense
  // position, so e.g. valid=3'b101 puts slot 0 at index 0 and slot 2 at 1.
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      dense_o[k] = '0;
    end
    cursor = 2'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (valid_i[k]) begin
        dense_o[cursor] = tag_i[k];
        cursor          = cursor + 2'd1;
      end
    end
  end

  assign count_o = popcount3(valid_i);

endmodule

// File: rtl/tag_release_queue.sv
// ---------------------------------------------------------------------------
// tag_release_queue
// Writer side of the physical-register free list. Collects up to three tags
// released at commit each cycle, buffers them in a small FIFO and drains them
// in order into the free list's three write ports, never faster than the free
// list has room for.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (free list must reset alongside)
//   bus  : tag_release_queue_if.slave; release slots, free-list write ports,
//          free-list occupancy and queue status
// ---------------------------------------------------------------------------
module tag_release_queue
  import release_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  tag_release_queue_if.slave  bus
);

  qptr_t rd_q, rd_d;
  qptr_t wr_q, wr_d;
  logic  ovf_q, ovf_d;
  tag_t  mem_q [QUEUE_DEPTH];

  qptr_t                count;
  qptr_t                freeSlots;
  logic                 ready;
  logic [NUM_PORTS-1:0] relValid;
  tag_t                 relTag   [NUM_PORTS];
  tag_t                 denseTag [NUM_PORTS];
  logic [1:0]           nIn;
  logic                 acceptEn;
  logic                 drop;
  flcnt_t               room;
  logic [1:0]           nOut;
  logic [NUM_PORTS-1:0] drainEn;
  tag_t                 drainTag [NUM_PORTS];

  // Occupancy and readiness come only from registered pointers, so a drain
  // happening in the same cycle does not make room for this cycle's releases.
  assign count     = wr_q - rd_q;
  assign freeSlots = qptr_t'(QUEUE_DEPTH) - count;
  assign ready     = (freeSlots >= qptr_t'(NUM_PORTS));

  assign relValid  = {bus.rel_valid_2, bus.rel_valid_1, bus.rel_valid_0};
  assign relTag[0] = bus.rel_tag_0;
  assign relTag[1] = bus.rel_tag_1;
  assign relTag[2] = bus.rel_tag_2;

  slot_compactor_3 u_compactor (
    .valid_i (relValid),
    .tag_i   (relTag),
    .dense_o (denseTag),
    .count_o (nIn)
  );

  // A release arriving while not ready is a commit-side protocol violation:
  // the whole cycle's releases are dropped rather than partially accepted.
  assign acceptEn = (|relValid) && ready;
  assign drop     = (|relValid) && !ready;

  // Drain width is the smallest of what is queued, the port count and the
  // free-list headroom. room < nOut implies room <= 2, so its low bits suffice.
  assign room = flcnt_t'(FL_DEPTH) - bus.fl_count;

  always_comb begin
    nOut = 2'd3;
    if (count < qptr_t'(NUM_PORTS)) begin
      nOut = count[1:0];
    end
    if (room < flcnt_t'(nOut)) begin
      nOut = room[1:0];
    end
  end

  // Drain ports read consecutive entries from the read pointer; the index
  // wraps naturally because only the low address bits are used.
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      drainEn[k]  = 1'b0;
      drainTag[k] = '0;
      if (2'(k) < nOut) begin
        drainEn[k]  = 1'b1;
        drainTag[k] = mem_q[rd_q[QADDR_WIDTH-1:0] + qidx_t'(k)];
      end
    end
  end

  // Pointer and error next-state.
  always_comb begin
    rd_d  = rd_q + qptr_t'(nOut);
    wr_d  = wr_q;
    ovf_d = ovf_q | drop;
    if (acceptEn) begin
      wr_d = wr_q + qptr_t'(nIn);
    end
  end

  // Pointer and sticky-error state; storage is left out of reset on purpose
  // since emptiness is fully described by the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      ovf_q <= ovf_d;
    end
  end

  // Accepted releases are written densely starting at the write pointer.
  always_ff @(posedge clk) begin
    if (acceptEn) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (2'(k) < nIn) begin
          mem_q[wr_q[QADDR_WIDTH-1:0] + qidx_t'(k)] <= denseTag[k];
        end
      end
    end
  end

  assign bus.rel_ready      = ready;
  assign bus.fl_write_en_0  = drainEn[0];
  assign bus.fl_write_en_1  = drainEn[1];
  assign bus.fl_write_en_2  = drainEn[2];
  assign bus.fl_write_tag_0 = drainTag[0];
  assign bus.fl_write_tag_1 = drainTag[1];
  assign bus.fl_write_tag_2 = drainTag[2];
  assign bus.queue_count    = count;
  assign bus.queue_empty    = (count == '0);
  assign bus.overflow_err   = ovf_q;

`ifndef SYNTHESIS
  // Simulation-only sanity checks on the surrounding logic.
  always @(posedge clk) begin
    if (!rst && (bus.fl_count > flcnt_t'(FL_DEPTH))) begin
      $error("tag_release_queue: fl_count %0d exceeds free-list depth", bus.fl_count);
    end
    if (!rst && drop) begin
      $warning("tag_release_queue: release dropped, queue lacked room (valid=%b)", relValid);
    end
  end
`endif

endmodule

// File: tb/tb_tag_release_queue.sv
// ---------------------------------------------------------------------------
// tb_tag_release_queue
// Directed self-checking bench for tag_release_queue.
// ---------------------------------------------------------------------------
module tb_tag_release_queue;
  import release_pkg::*;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  tag_release_queue_if bus ();

  tag_release_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] obsEn();
    return {bus.fl_write_en_2, bus.fl_write_en_1, bus.fl_write_en_0};
  endfunction

  function automatic logic [14:0] obsTags();
    return {bus.fl_write_tag_2, bus.fl_write_tag_1, bus.fl_write_tag_0};
  endfunction

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v, input int t0, input int t1, input int t2);
    bus.rel_valid_0 = v[0];
    bus.rel_valid_1 = v[1];
    bus.rel_valid_2 = v[2];
    bus.rel_tag_0   = tag_t'(t0);
    bus.rel_tag_1   = tag_t'(t1);
    bus.rel_tag_2   = tag_t'(t2);
  endtask

  // Reset values of every output.
  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(3'b000, 0, 0, 0);
    bus.fl_count = '0;
    step();
    step();
    assertCount++;
    if (bus.queue_count !== qptr_t'(0)) begin
      failCount++;
      $display("[TB] FAIL reset_count: got %0d expected 0", bus.queue_count);
    end
    assertCount++;
    if (bus.queue_empty !== 1'b1 || bus.rel_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got empty=%b ready=%b expected 1 1", bus.queue_empty, bus.rel_ready);
    end
    assertCount++;
    if (obsEn() !== 3'b000 || obsTags() !== 15'd0 || bus.overflow_err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got en=%b tags=%h ovf=%b expected 000 0 0", obsEn(), obsTags(), bus.overflow_err);
    end
    rst = 1'b0;
    step();
  endtask

  // Three releases in one cycle drain together one cycle later.
  task automatic test_triple();
    bus.fl_count = flcnt_t'(0);
    applyStimulus(3'b111, 5, 6, 7);
    #1;
    assertCount++;
    if (obsEn() !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL triple_no_bypass: got en=%b expected 000", obsEn());
    end
    step();
    applyStimulus(3'b000, 0, 0, 0);
    #1;
    assertCount++;
    if (obsEn() !== 3'b111 || obsTags() !== {5'd7, 5'd6, 5'd5}) begin
      failCount++;
      $display("[TB] FAIL triple_drain: got en=%b tags=%h expected 111 %h", obsEn(), obsTags(), {5'd7, 5'd6, 5'd5});
    end
    assertCount++;
    if (bus.queue_count !== qptr_t'(3)) begin
      failCount++;
      $display("[TB] FAIL triple_count: got %0d expected 3", bus.queue_count);
    end
    step();
    assertCount++;
    if (bus.queue_count !== qptr_t'(0) || bus.queue_empty !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL triple_empty: got count=%0d empty=%b expected 0 1", bus.queue_count, bus.queue_empty);
    end
  endtask

  // Sparse valid pattern is stored densely.
  task automatic test_sparse();
    applyStimulus(3'b101, 9, 3, 12);
    step();
    applyStimulus(3'b000, 0, 0, 0);
    #1;
    assertCount++;
    if (obsEn() !== 3'b011 || obsTags() !== {5'd0, 5'd12, 5'd9}) begin
      failCount++;
      $display("[TB] FAIL sparse_drain: got en=%b tags=%h expected 011 %h", obsEn(), obsTags(), {5'd0, 5'd12, 5'd9});
    end
    step();
    assertCount++;
    if (bus.queue_count !== qptr_t'(0)) begin
      failCount++;
      $display("[TB] FAIL sparse_empty: got %0d expected 0", bus.queue_count);
    end
  endtask

  // Free-list backpressure, rel_ready deassertion and sticky overflow.
  task automatic test_backpressure();
    bus.fl_count = flcnt_t'(32);
    applyStimulus(3'b111, 1, 2, 3);
    step();
    applyStimulus(3'b111, 4, 5, 6);
    step();
    applyStimulus(3'b000, 0, 0, 0);
    #1;
    assertCount++;
    if (bus.queue_count !== qptr_t'(6) || obsEn() !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL full_fl_hold: got count=%0d en=%b expected 6 000", bus.queue_count, obsEn());
    end
    assertCount++;
    if (bus.rel_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ready_low_at_6: got %b expected 0", bus.rel_ready);
    end
    step();
    assertCount++;
    if (bus.queue_count !== qptr_t'(6)) begin
      failCount++;
      $display("[TB] FAIL full_fl_still_6: got %0d expected 6", bus.queue_count);
    end
    applyStimulus(3'b001, 20, 0, 0);
    step();
    applyStimulus(3'b000, 0, 0, 0);
    #1;
    assertCount++;
    if (bus.overflow_err !== 1'b1 || bus.queue_count !== qptr_t'(6)) begin
      failCount++;
      $display("[TB] FAIL overflow_drop: got ovf=%b count=%0d expected 1 6", bus.overflow_err, bus.queue_count);
    end
    step();
    assertCount++;
    if (bus.overflow_err !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL overflow_sticky: got %b expected 1", bus.overflow_err);
    end
    bus.fl_count = flcnt_t'(31);
    #1;
    assertCount++;
    if (obsEn() !== 3'b001 || obsTags() !== {5'd0, 5'd0, 5'd1}) begin
      failCount++;
      $display("[TB] FAIL one_room: got en=%b tags=%h expected 001 %h", obsEn(), obsTags(), {5'd0, 5'd0, 5'd1});
    end
    step();
    assertCount++;
    if (bus.queue_count !== qptr_t'(5) || bus.rel_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL one_room_after: got count=%0d ready=%b expected 5 1", bus.queue_count, bus.rel_ready);
    end
    bus.fl_count = flcnt_t'(0);
    #1;
    assertCount++;
    if (obsEn() !== 3'b111 || obsTags() !== {5'd4, 5'd3, 5'd2}) begin
      failCount++;
      $display("[TB] FAIL order_after_hold: got en=%b tags=%h expected 111 %h", obsEn(), obsTags(), {5'd4, 5'd3, 5'd2});
    end
    step();
    assertCount++;
    if (obsEn() !== 3'b011 || obsTags() !== {5'd0, 5'd6, 5'd5}) begin
      failCount++;
      $display("[TB] FAIL tail_drain: got en=%b tags=%h expected 011 %h", obsEn(), obsTags(), {5'd0, 5'd6, 5'd5});
    end
    step();
    assertCount++;
    if (bus.queue_count !== qptr_t'(0) || bus.overflow_err !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL backpressure_end: got count=%0d ovf=%b expected 0 1", bus.queue_count, bus.overflow_err);
    end
  endtask

  // Reset while entries are queued discards them and clears the error.
  task automatic test_reset_mid();
    bus.fl_count = flcnt_t'(32);
    applyStimulus(3'b111, 10, 11, 12);
    step();
    applyStimulus(3'b011, 13, 14, 0);
    step();
    applyStimulus(3'b000, 0, 0, 0);
    #1;
    assertCount++;
    if (bus.queue_count !== qptr_t'(5)) begin
      failCount++;
      $display("[TB] FAIL pre_reset_count: got %0d expected 5", bus.queue_count);
    end
    bus.fl_count = flcnt_t'(0);
    rst = 1'b1;
    #1;
    assertCount++;
    if (bus.queue_count !== qptr_t'(0) || obsEn() !== 3'b000 || bus.overflow_err !== 1'b0 || bus.queue_empty !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL mid_reset: got count=%0d en=%b ovf=%b empty=%b expected 0 000 0 1", bus.queue_count, obsEn(), bus.overflow_err, bus.queue_empty);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  // Sustained 3-per-cycle traffic with 3 free-list slots wraps the pointers.
  task automatic test_back_to_back();
    logic [14:0] expTags;
    bus.fl_count = flcnt_t'(29);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'b111, (3*i) % 32, (3*i+1) % 32, (3*i+2) % 32);
      #1;
      if (i == 0) begin
        assertCount++;
        if (obsEn() !== 3'b000) begin
          failCount++;
          $display("[TB] FAIL wrap_first: got en=%b expected 000", obsEn());
        end
      end else begin
        expTags = {tag_t'((3*(i-1)+2) % 32), tag_t'((3*(i-1)+1) % 32), tag_t'((3*(i-1)) % 32)};
        assertCount++;
        if (obsEn() !== 3'b111 || obsTags() !== expTags || bus.queue_count !== qptr_t'(3)) begin
          failCount++;
          $display("[TB] FAIL wrap_cycle_%0d: got en=%b tags=%h count=%0d expected 111 %h 3", i, obsEn(), obsTags(), bus.queue_count, expTags);
        end
      end
      assertCount++;
      if (bus.rel_ready !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL wrap_ready_%0d: got %b expected 1", i, bus.rel_ready);
      end
      step();
    end
    applyStimulus(3'b000, 0, 0, 0);
    #1;
    expTags = {5'd27, 5'd26, 5'd25};
    assertCount++;
    if (obsEn() !== 3'b111 || obsTags() !== expTags) begin
      failCount++;
      $display("[TB] FAIL wrap_last: got en=%b tags=%h expected 111 %h", obsEn(), obsTags(), expTags);
    end
    step();
    assertCount++;
    if (bus.queue_count !== qptr_t'(0) || bus.overflow_err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL wrap_end: got count=%0d ovf=%b expected 0 0", bus.queue_count, bus.overflow_err);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    test_reset();
    test_triple();
    test_sparse();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/tag_release_queue.md
Name: tag_release_queue

Overview:
- Writer side of the physical-register free list. Collects register tags released at commit, up to 3 per cycle.
- Buffers them in a small FIFO.
- Drains them into the free list's 3 write ports, in order, only as fast as the free list has room.
- Sits between the commit stage and the free-list circular buffer; the free list's write_en_0..2 are driven from this block's fl_write_en_0..2.

Parameters:
- FL_DEPTH, 32, free-list depth (power of 2).
- TAG_WIDTH, $clog2(FL_DEPTH), released tag width.
- QUEUE_DEPTH, 8, internal FIFO depth (power of 2, >= 4).
- QADDR_WIDTH, $clog2(QUEUE_DEPTH), FIFO index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rel_valid_0/1/2  in  1 each  release request per commit slot; any pattern allowed.
- rel_tag_0/1/2  in  TAG_WIDTH each  tag released in that slot.
- rel_ready  out  1  queue can accept 3 releases this cycle.
- fl_count  in  TAG_WIDTH+1  current free-list occupancy (free list buffer_count).
- fl_write_en_0/1/2  out  1 each  free-list write enables, compacted (port k active implies ports <k active).
- fl_write_tag_0/1/2  out  TAG_WIDTH each  tag written on port k; '0 when the enable is low.
- queue_count  out  QADDR_WIDTH+1  entries held in the FIFO.
- queue_empty  out  1  queue_count == 0.
- overflow_err  out  1  sticky; a release was dropped.

Behaviour:
- State:
  - rd_ptr, wr_ptr: QADDR_WIDTH+1 bits each, with a wrap bit.
  - Storage: QUEUE_DEPTH x TAG_WIDTH.
  - overflow_err flop.
- Reset (async, rst=1):
  - rd_ptr=0, wr_ptr=0, overflow_err=0.
  - Storage contents are don't-care.
  - Outputs during reset: rel_ready=1, all fl_write_en=0, all fl_write_tag=0, queue_count=0, queue_empty=1.
- queue_count = wr_ptr - rd_ptr, computed modulo 2^(QADDR_WIDTH+1).
- rel_ready = (QUEUE_DEPTH - queue_count) >= 3. It is computed from registered state only; it does not credit same-cycle drains.
- Enqueue:
  - Valid slots are compacted in slot order 0,1,2. Example: valid=3'b101 writes tag_0 at wr_ptr and tag_2 at wr_ptr+1.
  - n_in = popcount(rel_valid). wr_ptr advances by n_in.
- Enqueue while rel_ready=0: the whole cycle's releases are dropped, wr_ptr holds, and overflow_err sets and stays 1 until reset. This is a commit-side protocol violation.
- Drain:
  - room = FL_DEPTH - fl_count.
  - n_out = min(queue_count, 3, room).
  - fl_write_en_k = (k < n_out).
  - fl_write_tag_k = storage[rd_ptr+k] (index wraps modulo QUEUE_DEPTH).
  - rd_ptr advances by n_out.
  - Drain outputs are combinational from registered state plus fl_count.
- Latency: a tag accepted at edge N is visible on fl_write_tag at earliest in cycle N+1. There is no enqueue-to-drain bypass.
- Simultaneous enqueue and drain are always legal:
  - count_next = count + n_in - n_out.
  - Drain reads only entries present before the edge.
- Ordering: strict FIFO across cycles and slot order within a cycle.
- Boundaries:
  - fl_count == FL_DEPTH gives n_out=0 and the queue holds its contents.
  - fl_count == FL_DEPTH-1 gives n_out <= 1.
  - Pointer wrap is handled by the wrap bit. Full is count == QUEUE_DEPTH; empty is count == 0.
- Reset mid-operation discards all queued tags. The free list must be reset in the same cycle.
- Simulation-only checks:
  - Error if fl_count > FL_DEPTH.
  - Warning on any dropped release.

Decomposition:
- Package release_pkg holds:
  - typedef tag_t (logic [TAG_WIDTH-1:0]).
  - typedef qptr_t (logic [QADDR_WIDTH:0]).
  - localparam NUM_PORTS = 3.
  - function popcount3.
- Sub-module slot_compactor_3 maps 3 valid/tag pairs to a dense 3-entry list plus a count. It is reused by the enqueue path.

Test Plan:
- Reset, then rel_valid=3'b111 with tags 5,6,7, fl_count=0 -> next cycle fl_write_en=3'b111 with tags 5,6,7; queue_count returns to 0 one edge later.
- rel_valid=3'b101 with tag_0=9, tag_2=12 -> stored densely; next cycle fl_write_en_0=1 (tag 9), fl_write_en_1=1 (tag 12), fl_write_en_2=0.
- Queue holds 6 entries, fl_count=31 -> fl_write_en=3'b001 only.
- Queue holds 6 entries, fl_count=32 -> all fl_write_en=0 and queue_count stays 6.
- Fill to 6 with fl_count=32 -> rel_ready=0. Push 1 more -> dropped, overflow_err=1 sticky, queue_count stays 6.
- 20 cycles of 3 releases per cycle with fl_count=29 (3 free slots) -> pointers wrap and order is preserved, with output order matching input order exactly.
- Assert rst while 5 entries are queued -> immediately queue_count=0, fl_write_en=0, overflow_err=0.
